cpu_run_ctrl: RTL and testbench

Conditions the raw board switches and step button, then generates the CPU's reset and clock-enable. It sits between the FPGA pins and the pipelined CPU. It replaces the bare divided clock with a single-clock-domain enable, supporting free-run, single-step and halt-freeze modes. Downstream logic (CPU, display source select) consumes `sw_clean`, `cpu_rst` and `cpu_ce`.

---
 rtl/cpu_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller: debounces board switches and the step button, then generates the CPU
// reset and one-cycle clock-enable. Define RUN_CTRL_STEP_EN to build the single-step mode.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned RUN_DIV         = 3_125_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] SW,
    input  logic        BTN_STEP,
    input  logic        halt,
    output logic [15:0] sw_clean,
    output logic        cpu_rst,
    output logic        cpu_ce,
    output logic [1:0]  mode,
    output logic [31:0] step_count
);
`ifdef RUN_CTRL_STEP_EN
    localparam int unsigned NIN = 17;
`else
    localparam int unsigned NIN = 16;
`endif
    localparam int unsigned TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_e;

    logic [NIN-1:0] raw_in;
    logic [NIN-1:0] sync1_q, sync2_q;
    logic [NIN-1:0] samp_q, samp_d;
    logic [NIN-1:0] clean_q, clean_d;
    logic [NIN-1:0] agree;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic           tick;
    logic [DW-1:0]  div_q, div_d;
    logic           div_terminal;
    state_e         state_q, state_d;
    logic           cpu_ce_q, cpu_ce_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic [31:0]    step_count_q, step_count_d;
    logic           step_sel;
    logic           step_edge;

`ifdef RUN_CTRL_STEP_EN
    logic btn_prev_q;

    assign raw_in    = {BTN_STEP, SW};
    assign step_sel  = clean_q[2];
    // Edge only in STEP, but the history tracks the button in every state.
    assign step_edge = clean_q[NIN-1] & ~btn_prev_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) btn_prev_q <= 1'b0;
        else        btn_prev_q <= clean_q[NIN-1];
    end
`else
    logic unused_btn;

    assign raw_in     = SW;
    assign step_sel   = 1'b0;
    assign step_edge  = 1'b0;
    assign unused_btn = BTN_STEP;
`endif

    assign tick         = (tick_cnt_q == TW'(DEBOUNCE_CYCLES - 1));
    assign div_terminal = (div_q == DW'(RUN_DIV - 1));
    assign agree        = ~(sync2_q ^ samp_q);

    // Debounce: a clean bit follows its input only when two successive samples agree.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        samp_d     = samp_q;
        clean_d    = clean_q;
        if (tick) begin
            samp_d  = sync2_q;
            clean_d = (agree & sync2_q) | (~agree & clean_q);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!clean_q[0]) begin
            state_d = HOLD;
        end else begin
            unique case (state_q)
                HOLD: state_d = step_sel ? STEP : RUN;
                RUN: begin
                    if (halt)          state_d = HALT;
                    else if (step_sel) state_d = STEP;
                end
                STEP: begin
                    if (halt)            state_d = HALT;
                    else if (!step_sel)  state_d = RUN;
                end
                HALT: state_d = HALT;
            endcase
        end
    end

    // Enable generation; any state change in the same cycle suppresses the pulse.
    always_comb begin
        div_d = div_terminal ? '0 : div_q + DW'(1);
        if ((state_d != state_q) && ((state_d == RUN) || (state_d == HOLD))) begin
            div_d = '0;
        end

        cpu_ce_d = 1'b0;
        if (state_d == state_q) begin
            unique case (state_q)
                HOLD:    cpu_ce_d = div_terminal;
                RUN:     cpu_ce_d = div_terminal;
                STEP:    cpu_ce_d = step_edge;
                HALT:    cpu_ce_d = 1'b0;
            endcase
        end

        step_count_d = step_count_q;
        if (state_d == HOLD)  step_count_d = '0;
        else if (cpu_ce_d)    step_count_d = step_count_q + 32'd1;

        cpu_rst_d = ~clean_d[0];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            samp_q       <= '0;
            clean_q      <= '0;
            tick_cnt_q   <= '0;
            div_q        <= '0;
            state_q      <= HOLD;
            cpu_ce_q     <= 1'b0;
            cpu_rst_q    <= 1'b1;
            step_count_q <= '0;
        end else begin
            sync1_q      <= raw_in;
            sync2_q      <= sync1_q;
            samp_q       <= samp_d;
            clean_q      <= clean_d;
            tick_cnt_q   <= tick_cnt_d;
            div_q        <= div_d;
            state_q      <= state_d;
            cpu_ce_q     <= cpu_ce_d;
            cpu_rst_q    <= cpu_rst_d;
            step_count_q <= step_count_d;
        end
    end

    assign sw_clean   = clean_q[15:0];
    assign cpu_rst    = cpu_rst_q;
    assign cpu_ce     = cpu_ce_q;
    assign mode       = state_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=8.
module tb_cpu_run_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] SW;
    logic        BTN_STEP;
    logic        halt;
    logic [15:0] sw_clean;
    logic        cpu_rst;
    logic        cpu_ce;
    logic [1:0]  mode;
    logic [31:0] step_count;

    int total = 0;
    int bad   = 0;

`ifdef RUN_CTRL_STEP_EN
    localparam logic [1:0] M_SEL = 2'd2;
`else
    localparam logic [1:0] M_SEL = 2'd1;
`endif

    typedef struct {
        logic [15:0] sw;
        logic        halt;
        logic [1:0]  mode;
        logic        rst;
    } vec_t;

    vec_t vecs [12];

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8)) dut (
        .CLK(CLK), .RESET(RESET), .SW(SW), .BTN_STEP(BTN_STEP), .halt(halt),
        .sw_clean(sw_clean), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .mode(mode),
        .step_count(step_count)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_mode(input logic [1:0] m, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (mode == m) break;
            tick();
        end
        check(name, 32'(mode), 32'(m));
    endtask

    task automatic wait_pulse(input int bound, input string name);
        int i;
        for (i = 0; i < bound; i++) begin
            tick();
            if (cpu_ce) break;
        end
        check(name, 32'(cpu_ce), 32'd1);
    endtask

    task automatic count_ce(input int n, input logic [1:0] m, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (cpu_ce && mode == m) cnt++;
        end
    endtask

    initial begin
        int viol;
        int gap;
        int pulses;
        int c;

        vecs[0]  = '{sw: 16'h0000, halt: 1'b0, mode: 2'd0,  rst: 1'b1};
        vecs[1]  = '{sw: 16'h0001, halt: 1'b0, mode: 2'd1,  rst: 1'b0};
        vecs[2]  = '{sw: 16'hA5A1, halt: 1'b0, mode: 2'd1,  rst: 1'b0};
        vecs[3]  = '{sw: 16'h0001, halt: 1'b1, mode: 2'd3,  rst: 1'b0};
        vecs[4]  = '{sw: 16'h0001, halt: 1'b0, mode: 2'd3,  rst: 1'b0};
        vecs[5]  = '{sw: 16'h0000, halt: 1'b0, mode: 2'd0,  rst: 1'b1};
        vecs[6]  = '{sw: 16'h0005, halt: 1'b0, mode: M_SEL, rst: 1'b0};
        vecs[7]  = '{sw: 16'h0005, halt: 1'b1, mode: 2'd3,  rst: 1'b0};
        vecs[8]  = '{sw: 16'hFFFE, halt: 1'b0, mode: 2'd0,  rst: 1'b1};
        vecs[9]  = '{sw: 16'hFFFF, halt: 1'b0, mode: M_SEL, rst: 1'b0};
        vecs[10] = '{sw: 16'hFFFB, halt: 1'b0, mode: 2'd1,  rst: 1'b0};
        vecs[11] = '{sw: 16'h0000, halt: 1'b0, mode: 2'd0,  rst: 1'b1};

        RESET = 1'b1; SW = '0; BTN_STEP = 1'b0; halt = 1'b0;
        #2 RESET = 1'b0;
        #1;
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_sw_clean", 32'(sw_clean), 32'd0);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_step_count", step_count, 32'd0);
        repeat (3) tick();

        // Debounce: release reset and start toggling SW[0] every 3 cycles on the same edge.
        RESET = 1'b1;
        viol = 0;
        for (int j = 0; j < 40; j++) begin
            SW[0] = ((j / 3) % 2) == 0;
            tick();
            if (sw_clean[0] !== 1'b0) viol++;
        end
        check("deb_toggle_violations", 32'(viol), 32'd0);
        SW[0] = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (sw_clean[0]) break;
        end
        check("deb_settle", 32'(sw_clean[0]), 32'd1);
        check("deb_cpu_rst", 32'(cpu_rst), 32'd0);

        // Free run: first pulse RUN_DIV after entering RUN, then every RUN_DIV.
        wait_mode(2'd1, 4, "run_enter");
        gap = 0;
        pulses = 0;
        for (int i = 0; i < 120 && pulses < 10; i++) begin
            tick();
            gap++;
            if (cpu_ce) begin
                check($sformatf("run_gap%0d", pulses), 32'(gap), 32'd8);
                gap = 0;
                pulses++;
            end
        end
        check("run_pulses", 32'(pulses), 32'd10);
        check("run_step_count", step_count, 32'd10);

        // Halt raised during the divider terminal cycle wins over the pulse.
        repeat (7) tick();
        halt = 1'b1;
        tick();
        check("halt_mode", 32'(mode), 32'd3);
        check("halt_no_ce", 32'(cpu_ce), 32'd0);
        check("halt_count_frozen", step_count, 32'd10);
        halt = 1'b0;
        count_ce(20, 2'd3, c);
        check("halt_ce_count", 32'(c), 32'd0);
        check("halt_count_still", step_count, 32'd10);
        check("halt_mode_sticky", 32'(mode), 32'd3);
        SW = 16'h0000;
        wait_mode(2'd0, 30, "halt_to_hold");
        check("hold_count_clear", step_count, 32'd0);
        check("hold_cpu_rst", 32'(cpu_rst), 32'd1);

        // Table of steady-state switch/halt settings.
        for (int i = 0; i < 12; i++) begin
            SW   = vecs[i].sw;
            halt = vecs[i].halt;
            repeat (24) tick();
            check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
            check($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].rst));
            check($sformatf("vec%0d_sw_clean", i), 32'(sw_clean), 32'(vecs[i].sw));
        end
        halt = 1'b0;

        // Asynchronous reset mid-RUN, landing on a pulse cycle.
        SW = 16'h0001;
        wait_mode(2'd1, 30, "mrst_run");
        pulses = 0;
        for (int i = 0; i < 60 && pulses < 5; i++) begin
            tick();
            if (cpu_ce) pulses++;
        end
        check("mrst_pre_count", step_count, 32'd5);
        #2 RESET = 1'b0;
        #1;
        check("mrst_mode", 32'(mode), 32'd0);
        check("mrst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("mrst_step_count", step_count, 32'd0);
        check("mrst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("mrst_sw_clean", 32'(sw_clean), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;

        // Counter wrap from all-ones.
        wait_mode(2'd1, 40, "wrap_run");
        wait_pulse(20, "wrap_first_pulse");
        force dut.step_count_q = 32'hFFFF_FFFF;
        #1 release dut.step_count_q;
        wait_pulse(20, "wrap_pulse");
        check("wrap_zero", step_count, 32'd0);
        wait_pulse(20, "wrap_pulse2");
        check("wrap_one", step_count, 32'd1);

`ifdef RUN_CTRL_STEP_EN
        SW = 16'h0000;
        wait_mode(2'd0, 40, "step_hold");
        SW = 16'h0005;
        wait_mode(2'd2, 40, "step_enter");
        pulses = 0;
        for (int p = 0; p < 3; p++) begin
            BTN_STEP = 1'b1;
            count_ce(20, 2'd2, c);
            pulses += c;
            BTN_STEP = 1'b0;
            count_ce(20, 2'd2, c);
            pulses += c;
        end
        check("step_three_pulses", 32'(pulses), 32'd3);
        check("step_three_count", step_count, 32'd3);
        BTN_STEP = 1'b1;
        count_ce(100, 2'd2, c);
        pulses = c;
        BTN_STEP = 1'b0;
        count_ce(20, 2'd2, c);
        pulses += c;
        check("step_long_press", 32'(pulses), 32'd1);
        check("step_long_count", step_count, 32'd4);

        // A press made in RUN must not fire after switching to STEP.
        SW = 16'h0001;
        wait_mode(2'd1, 40, "step_to_run");
        BTN_STEP = 1'b1;
        count_ce(25, 2'd2, c);
        SW = 16'h0005;
        count_ce(40, 2'd2, c);
        check("step_stale_press", 32'(c), 32'd0);
        check("step_stale_mode", 32'(mode), 32'd2);
        BTN_STEP = 1'b0;
        count_ce(20, 2'd2, c);
        check("step_stale_release", 32'(c), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
